// File: rtl/fft_host_seq.sv
// Host-side sequencer for the FFT controller: accepts one job, waits for the
// controller to go idle, writes config, starts it, counts output samples,
// then soft-stops, waits for the drain and reports done or error.
module fft_host_seq #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [31:0]      job_config,
    input  logic [CNT_W-1:0] job_samples,
    input  logic             abort,
    output logic [31:0]      out_config,
    output logic [31:0]      out_command,
    output logic [1:0]       config_valid,
    input  logic [31:0]      status,
    input  logic             out_sample_valid,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] samples_seen
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_CONFIG,
        S_START,
        S_RUN,
        S_STOP,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      cfg;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cnt_inc;
    logic [TW-1:0]    tmo;
    logic             tmo_hit;
    logic             cnt_en;
    logic             accept;
    logic             ctrl_idle;
    logic             unused_status;

    // Saturating increment so a runaway sample stream cannot wrap the count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Only bit 0 of the controller status carries meaning here.
    assign ctrl_idle     = status[0];
    assign unused_status = ^status[31:1];

    assign accept  = (state == S_IDLE) && job_valid;
    assign cnt_en  = out_sample_valid &&
                     ((state == S_RUN) || (state == S_STOP) || (state == S_DRAIN));
    assign cnt_inc = sat_inc(samples_seen);
    assign tmo_hit = (tmo == TW'(TIMEOUT - 1)) && !ctrl_idle;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; controller-idle wins over a timeout in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (job_valid) begin
                    state_next = (job_samples == '0) ? S_ERR : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (ctrl_idle) begin
                    state_next = S_CONFIG;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_CONFIG: state_next = S_START;
            S_START:  state_next = S_RUN;
            S_RUN: begin
                if (abort || (out_sample_valid && (cnt_inc == target))) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: state_next = S_DRAIN;
            S_DRAIN: begin
                if (ctrl_idle) begin
                    state_next = S_DONE;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Job latches and sample counter; the count holds after DONE/ERR until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg          <= '0;
            target       <= '0;
            samples_seen <= '0;
        end else if (accept) begin
            cfg          <= job_config;
            target       <= job_samples;
            samples_seen <= '0;
        end else if (cnt_en) begin
            samples_seen <= cnt_inc;
        end
    end

    // Timeout counter runs only in the two waiting states, so it restarts on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo <= '0;
        end else if ((state == S_WAIT_IDLE) || (state == S_DRAIN)) begin
            tmo <= tmo + TW'(1);
        end else begin
            tmo <= '0;
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        config_valid = 2'd0;
        out_command  = 32'd0;
        case (state)
            S_CONFIG: config_valid = 2'd1;
            S_START: begin
                config_valid = 2'd2;
                out_command  = 32'd1;
            end
            S_STOP: begin
                config_valid = 2'd2;
                out_command  = 32'd2;
            end
            default: ;
        endcase
    end

    assign out_config = cfg;
    assign job_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERR);

endmodule

// File: tb/tb_fft_host_seq.sv
// Self-checking bench for fft_host_seq: each job is planned as a per-cycle
// stimulus table, and the expected event timeline and sample count are
// derived from that table with plain arithmetic.
module tb_fft_host_seq;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int MAXL    = 700;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             job_valid;
    logic             job_ready;
    logic [31:0]      job_config;
    logic [CNT_W-1:0] job_samples;
    logic             abort;
    logic [31:0]      out_config;
    logic [31:0]      out_command;
    logic [1:0]       config_valid;
    logic [31:0]      status;
    logic             out_sample_valid;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] samples_seen;

    int n_chk  = 0;
    int n_pass = 0;

    bit st_a [MAXL];
    bit sm_a [MAXL];
    bit ab_a [MAXL];

    fft_host_seq #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_config       (job_config),
        .job_samples      (job_samples),
        .abort            (abort),
        .out_config       (out_config),
        .out_command      (out_command),
        .config_valid     (config_valid),
        .status           (status),
        .out_sample_valid (out_sample_valid),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .samples_seen     (samples_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_job_ready"}, 32'(job_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_config_valid"}, 32'(config_valid), 32'd0);
        chk({tag, "_out_command"}, out_command, 32'd0);
        chk({tag, "_out_config"}, out_config, 32'd0);
        chk({tag, "_samples_seen"}, 32'(samples_seen), 32'd0);
    endtask

    task automatic rand_inputs();
        job_valid        = 1'($urandom_range(0, 1));
        job_config       = $urandom;
        job_samples      = CNT_W'($urandom);
        abort            = 1'($urandom_range(0, 1));
        status           = $urandom;
        out_sample_valid = 1'($urandom_range(0, 1));
    endtask

    // Plans one job as a per-cycle table, then drives it and checks every cycle.
    // Cycle i means the interval just after clock edge i; the job is offered in cycle 0.
    task automatic run_job(input logic [31:0] cfg, input int n, input int w,
                           input bit use_abort, input int nrun, input bit abort_smp,
                           input int dw, input int ndrain, input bit dense);
        int r, s, cnt, dl, endi, cfg_i, st_i, sp_i, exp_cnt;
        bit is_err;
        logic [31:0] stv;
        for (int i = 0; i < MAXL; i++) begin
            st_a[i] = 1'b0; sm_a[i] = 1'b0; ab_a[i] = 1'b0;
        end
        cfg_i = -1; st_i = -1; sp_i = -1; is_err = 1'b0; exp_cnt = 0;
        if (n == 0) begin
            endi = 1; is_err = 1'b1;
        end else if (w >= TIMEOUT) begin
            endi = 1 + TIMEOUT; is_err = 1'b1;
            for (int i = 1; i <= endi; i++) sm_a[i] = 1'($urandom_range(0, 1));
        end else begin
            st_a[1 + w] = 1'b1;
            cfg_i = w + 2; st_i = w + 3; r = w + 4;
            for (int i = 1; i < r; i++) sm_a[i] = 1'($urandom_range(0, 1));
            for (int i = w + 2; i < r; i++) st_a[i] = 1'($urandom_range(0, 1));
            cnt = 0; s = r;
            while (1) begin
                st_a[s] = 1'($urandom_range(0, 1));
                if (use_abort && cnt == nrun) begin
                    ab_a[s] = 1'b1; sm_a[s] = abort_smp;
                    break;
                end
                sm_a[s] = dense ? 1'b1 : ($urandom_range(0, 2) != 0);
                if (sm_a[s]) cnt++;
                if (cnt == n) break;
                s++;
            end
            sp_i = s + 1;
            st_a[sp_i] = 1'($urandom_range(0, 1));
            sm_a[sp_i] = 1'($urandom_range(0, 1));
            if (dw >= TIMEOUT) begin
                dl = s + 1 + TIMEOUT; is_err = 1'b1;
            end else begin
                dl = s + 2 + dw; st_a[dl] = 1'b1;
            end
            endi = dl + 1;
            for (int k = 0; k < ndrain && sp_i + 1 + k <= dl; k++) sm_a[sp_i + 1 + k] = 1'b1;
            sm_a[endi] = 1'($urandom_range(0, 1));
            for (int i = r; i <= dl; i++)
                if (sm_a[i] && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        end

        for (int i = 0; i <= endi + 1; i++) begin
            chk("busy", 32'(busy), 32'(i >= 1 && i <= endi));
            chk("job_ready", 32'(job_ready), 32'(!(i >= 1 && i <= endi)));
            chk("done", 32'(done), 32'(i == endi && !is_err));
            chk("error", 32'(error), 32'(i == endi && is_err));
            chk("config_valid", 32'(config_valid),
                (i == cfg_i) ? 32'd1 : (i == st_i || i == sp_i) ? 32'd2 : 32'd0);
            chk("out_command", out_command,
                (i == st_i) ? 32'd1 : (i == sp_i) ? 32'd2 : 32'd0);
            if (i >= 1) chk("out_config", out_config, cfg);
            if (i == 1) chk("samples_clear", 32'(samples_seen), 32'd0);
            if (i >= endi) chk("samples_seen", 32'(samples_seen), 32'(exp_cnt));
            job_valid        = (i == 0) ? 1'b1 : (i <= endi) ? 1'($urandom_range(0, 1)) : 1'b0;
            job_config       = (i == 0) ? cfg : $urandom;
            job_samples      = (i == 0) ? CNT_W'(n) : CNT_W'($urandom);
            stv              = $urandom;
            stv[0]           = st_a[i];
            status           = stv;
            out_sample_valid = sm_a[i];
            abort            = ab_a[i];
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w, nrun, dw, ndrain;
        bit use_abort;
        rst_n = 1'b0;
        rand_inputs();
        #1;
        chk_reset_outputs("reset_t0");
        repeat (3) begin
            @(posedge clk); #1;
            rand_inputs();
            #1;
            chk_reset_outputs("reset_hold");
        end
        job_valid = 1'b0; abort = 1'b0; out_sample_valid = 1'b0; status = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk_reset_outputs("reset_release");
        @(posedge clk); #1;
        chk_reset_outputs("reset_after");

        // Normal job, busy controller, illegal job, both timeouts, abort, saturation.
        run_job(32'h8800_0010, 4, 0, 1'b0, 0, 1'b0, 2, 0, 1'b0);
        run_job(32'h1234_5678, 3, 10, 1'b0, 0, 1'b0, 1, 2, 1'b0);
        run_job(32'hDEAD_0000, 0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        run_job(32'h0000_00FF, 2, 0, 1'b0, 0, 1'b0, TIMEOUT, 0, 1'b0);
        run_job(32'h0F0F_0F0F, 2, TIMEOUT, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        run_job(32'hCAFE_0001, 5, TIMEOUT - 1, 1'b0, 0, 1'b0, TIMEOUT - 1, 1, 1'b0);
        run_job(32'hABCD_0100, 100, 0, 1'b1, 2, 1'b0, 5, 3, 1'b0);
        run_job(32'hABCD_0101, 6, 1, 1'b1, 5, 1'b1, 3, 0, 1'b0);
        run_job(32'h5A5A_0002, 254, 0, 1'b0, 0, 1'b0, 4, 3, 1'b1);
        run_job(32'h5A5A_0003, 255, 2, 1'b0, 0, 1'b0, 3, 2, 1'b1);

        for (int j = 0; j < 25; j++) begin
            n         = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
            w         = int'($urandom_range(0, 18));
            use_abort = (n > 1) && ($urandom_range(0, 2) == 0);
            nrun      = (n > 1) ? int'($urandom_range(0, n - 1)) : 0;
            dw        = int'($urandom_range(0, 18));
            ndrain    = int'($urandom_range(0, 4));
            run_job($urandom, n, w, use_abort, nrun, 1'($urandom_range(0, 1)), dw, ndrain, 1'b0);
        end

        // Reset asserted in the middle of RUN takes effect without a clock edge.
        job_valid = 1'b1; job_config = 32'hA5A5_0001; job_samples = CNT_W'(50);
        status = 32'd1; out_sample_valid = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        job_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("midrun_busy", 32'(busy), 32'd1);
        chk("midrun_out_config", out_config, 32'hA5A5_0001);
        out_sample_valid = 1'b1;
        @(posedge clk); #1;
        chk("midrun_count", 32'(samples_seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        out_sample_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
